// File: rtl/ysyx_lsu_axi_wr.sv
// LSU store-queue head to AXI write channel bridge; one transaction in flight at a time.
// Define YSYX_LSU_AXI_WR_TIMEOUT_EN to add a watchdog that aborts a stalled write with an error.
module ysyx_lsu_axi_wr #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            lsu_awvalid,
  input  logic [XLEN-1:0] lsu_awaddr,
  input  logic            lsu_wvalid,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic [3:0]      lsu_wstrb,
  output logic            lsu_wready,
  output logic            lsu_werr,
  output logic            awvalid,
  input  logic            awready,
  output logic [XLEN-1:0] awaddr,
  output logic [2:0]      awsize,
  output logic            wvalid,
  input  logic            wready,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp
);

  typedef enum logic [1:0] {IDLE, SEND, RESP, DONE} state_t;

  state_t          state, state_nxt;
  logic            aw_done, w_done, err;
  logic            accept, busy, timeout;
  logic [XLEN-1:0] addr_p0, wdata_p0;
  logic [3:0]      wstrb_p0;
  logic [2:0]      size_p0;

  function automatic logic [XLEN-1:0] align_data(input logic [XLEN-1:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [3:0] align_strb(input logic [3:0] s, input logic [1:0] off);
    return s << off;
  endfunction

  function automatic logic [2:0] size_of(input logic [3:0] s);
    case (s)
      4'h1:    return 3'd0;
      4'h3:    return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  assign accept = (state == IDLE) && lsu_awvalid && lsu_wvalid;
  assign busy   = (state == SEND) || (state == RESP);

`ifdef YSYX_LSU_AXI_WR_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdog;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    wdog <= 8'd0;
    else if (busy) wdog <= wdog + 8'd1;
    else           wdog <= 8'd0;
  end

  // The cycle that completes the count is the last one spent waiting.
  assign timeout = busy && (wdog == WDOG_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: begin
        if (timeout)                state_nxt = DONE;
        else if (aw_done && w_done) state_nxt = RESP;
      end
      RESP: if (timeout || bvalid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (state == SEND) begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (timeout)                       err <= 1'b1;
      else if ((state == RESP) && bvalid) err <= (bresp != 2'b00);
    end
  end

  // Capture stage: request is aligned once here and held for the whole transaction.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_p0  <= lsu_awaddr;
      wdata_p0 <= align_data(lsu_wdata, lsu_awaddr[1:0]);
      wstrb_p0 <= align_strb(lsu_wstrb, lsu_awaddr[1:0]);
      size_p0  <= size_of(lsu_wstrb);
    end
  end

  assign awvalid    = (state == SEND) && !aw_done;
  assign wvalid     = (state == SEND) && !w_done;
  assign bready     = (state == RESP);
  assign lsu_wready = (state == DONE);
  assign lsu_werr   = (state == DONE) && err;
  assign awaddr     = addr_p0;
  assign awsize     = size_p0;
  assign wdata      = wdata_p0;
  assign wstrb      = wstrb_p0;
  assign wlast      = 1'b1;

endmodule

// File: tb/tb_ysyx_lsu_axi_wr.sv
// Bench for ysyx_lsu_axi_wr: directed vector table, randomized transactions and reset/timeout corners.
module tb_ysyx_lsu_axi_wr;

  logic        clock, reset;
  logic        lsu_awvalid, lsu_wvalid, lsu_wready, lsu_werr;
  logic [31:0] lsu_awaddr, lsu_wdata, awaddr, wdata;
  logic [3:0]  lsu_wstrb, wstrb;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [2:0]  awsize;
  logic [1:0]  bresp;

  int vecs = 0;
  int errs = 0;

  ysyx_lsu_axi_wr #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wready(lsu_wready), .lsu_werr(lsu_werr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          a;
    int          w;
    int          b;
    logic [1:0]  br;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [2:0]  e_size;
    int          e_d;
    logic        e_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: byte lane placement by plain arithmetic.
  function automatic logic [31:0] m_wdata(input logic [31:0] addr, input logic [31:0] data);
    longint unsigned scale = 1;
    for (int k = 0; k < int'(addr % 4); k++) scale = scale * 256;
    return 32'((longint'(data) * scale) % 64'h1_0000_0000);
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [31:0] addr, input logic [3:0] strb);
    return 4'((int'(strb) * (2 ** int'(addr % 4))) % 16);
  endfunction

  function automatic logic [2:0] m_size(input logic [3:0] strb);
    if (strb == 4'h1) return 3'd0;
    if (strb == 4'h3) return 3'd1;
    return 3'd2;
  endfunction

  // Completion cycle: both channels handshake, one bookkeeping cycle, then RESP until bvalid.
  function automatic int m_done(input int a, input int w, input int b);
    int h, r;
    h = ((a < 1) ? 1 : a);
    if (w > h) h = w;
    r = h + 2;
    return ((r > b) ? r : b) + 1;
  endfunction

  // Called at a negedge; the request is captured at the following posedge (cycle 0).
  // a/w/b: first cycle in which awready/wready/bvalid are offered.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int a, input int w, input int b, input logic [1:0] br,
                         input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                         input logic [2:0] e_size, input int e_d, input logic e_err,
                         input string tag);
    int haw, hw, r;
    logic aw_exp, w_exp;
    haw = (a < 1) ? 1 : a;
    hw  = (w < 1) ? 1 : w;
    r   = ((haw > hw) ? haw : hw) + 2;
    lsu_awvalid = 1'b1;
    lsu_wvalid  = 1'b1;
    lsu_awaddr  = addr;
    lsu_wdata   = data;
    lsu_wstrb   = strb;
    awready     = (a <= 0);
    wready      = (w <= 0);
    bvalid      = (b <= 0);
    bresp       = br;
    for (int n = 1; n <= e_d + 1; n++) begin
      @(negedge clock);
      aw_exp = (n <= haw) && (n < e_d);
      w_exp  = (n <= hw) && (n < e_d);
      chk($sformatf("%s c%0d awvalid", tag, n), 32'(awvalid), 32'(aw_exp));
      chk($sformatf("%s c%0d wvalid", tag, n), 32'(wvalid), 32'(w_exp));
      chk($sformatf("%s c%0d bready", tag, n), 32'(bready), 32'((n >= r) && (n < e_d)));
      chk($sformatf("%s c%0d lsu_wready", tag, n), 32'(lsu_wready), 32'(n == e_d));
      chk($sformatf("%s c%0d lsu_werr", tag, n), 32'(lsu_werr), 32'((n == e_d) && e_err));
      if (aw_exp) begin
        chk($sformatf("%s c%0d awaddr", tag, n), awaddr, addr);
        chk($sformatf("%s c%0d awsize", tag, n), 32'(awsize), 32'(e_size));
      end
      if (w_exp) begin
        chk($sformatf("%s c%0d wdata", tag, n), wdata, e_wdata);
        chk($sformatf("%s c%0d wstrb", tag, n), 32'(wstrb), 32'(e_wstrb));
        chk($sformatf("%s c%0d wlast", tag, n), 32'(wlast), 32'd1);
      end
      // Foreign requests while busy must be ignored; one is always held through DONE.
      lsu_awvalid = (n == e_d) ? 1'b1 : 1'($urandom_range(0, 1));
      lsu_wvalid  = lsu_awvalid;
      lsu_awaddr  = $urandom;
      lsu_wdata   = $urandom;
      lsu_wstrb   = 4'hF;
      awready     = (n >= a);
      wready      = (n >= w);
      bvalid      = (n >= b);
    end
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
  endtask

  task automatic idle_gap(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      lsu_awvalid = 1'b0;
      lsu_wvalid  = 1'b0;
      awready     = 1'($urandom_range(0, 1));
      wready      = 1'($urandom_range(0, 1));
      bvalid      = 1'($urandom_range(0, 1));
      bresp       = 2'($urandom_range(0, 3));
      @(negedge clock);
      chk($sformatf("gap%0d awvalid", k), 32'(awvalid), 32'd0);
      chk($sformatf("gap%0d wvalid", k), 32'(wvalid), 32'd0);
      chk($sformatf("gap%0d bready", k), 32'(bready), 32'd0);
      chk($sformatf("gap%0d lsu_wready", k), 32'(lsu_wready), 32'd0);
    end
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [3:0]  rs;
    logic [1:0]  rb;
    int          a, w, b;

    tbl[0] = '{32'h8000_0003, 32'h0000_00AB, 4'h1, 0, 0, 0,  2'b00, 32'hAB00_0000, 4'h8, 3'd0, 4,  1'b0};
    tbl[1] = '{32'h0F00_0002, 32'h0000_1234, 4'h3, 1, 4, 0,  2'b00, 32'h1234_0000, 4'hC, 3'd1, 7,  1'b0};
    tbl[2] = '{32'hA000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0,  2'b10, 32'hDEAD_BEEF, 4'hF, 3'd2, 4,  1'b1};
    tbl[3] = '{32'h1000_0001, 32'h0000_00C3, 4'h1, 3, 0, 5,  2'b11, 32'h0000_C300, 4'h2, 3'd0, 6,  1'b1};
    tbl[4] = '{32'h2000_0003, 32'h0000_BEEF, 4'h3, 0, 2, 10, 2'b01, 32'hEF00_0000, 4'h8, 3'd1, 11, 1'b1};
    tbl[5] = '{32'h3000_0001, 32'h1122_3344, 4'hF, 2, 2, 0,  2'b00, 32'h2233_4400, 4'hE, 3'd2, 5,  1'b0};
    tbl[6] = '{32'h0000_0002, 32'h0000_00FF, 4'h1, 0, 5, 2,  2'b00, 32'h00FF_0000, 4'h4, 3'd0, 8,  1'b0};
    tbl[7] = '{32'h0000_0001, 32'h0000_ABCD, 4'h3, 0, 0, 0,  2'b00, 32'h00AB_CD00, 4'h6, 3'd1, 4,  1'b0};

    reset       = 1'b0;
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    lsu_awaddr  = '0;
    lsu_wdata   = '0;
    lsu_wstrb   = '0;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    bresp       = 2'b00;
    repeat (3) @(negedge clock);
    chk("reset awvalid", 32'(awvalid), 32'd0);
    chk("reset wvalid", 32'(wvalid), 32'd0);
    chk("reset bready", 32'(bready), 32'd0);
    chk("reset lsu_wready", 32'(lsu_wready), 32'd0);
    chk("reset lsu_werr", 32'(lsu_werr), 32'd0);
    reset = 1'b1;

    // Table entries run back to back: each next request is already valid during DONE.
    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].a, tbl[i].w, tbl[i].b, tbl[i].br,
              tbl[i].e_wdata, tbl[i].e_wstrb, tbl[i].e_size, tbl[i].e_d, tbl[i].e_err,
              $sformatf("vec%0d", i));
    idle_gap(2);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rd = $urandom;
      case ($urandom_range(0, 2))
        0:       rs = 4'h1;
        1:       rs = 4'h3;
        default: rs = 4'hF;
      endcase
      rb = 2'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 4));
      w  = int'($urandom_range(0, 4));
      b  = int'($urandom_range(0, 8));
      run_txn(ra, rd, rs, a, w, b, rb, m_wdata(ra, rd), m_wstrb(ra, rs), m_size(rs),
              m_done(a, w, b), (rb != 2'b00), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle_gap(int'($urandom_range(1, 2)));
    end

    // Reset while waiting for the write response drops the transaction.
    lsu_awvalid = 1'b1;
    lsu_wvalid  = 1'b1;
    lsu_awaddr  = 32'h4000_0000;
    lsu_wdata   = 32'h5555_AAAA;
    lsu_wstrb   = 4'hF;
    awready     = 1'b1;
    wready      = 1'b1;
    bvalid      = 1'b0;
    repeat (3) begin
      @(negedge clock);
      lsu_awvalid = 1'b0;
      lsu_wvalid  = 1'b0;
    end
    chk("rstmid bready in RESP", 32'(bready), 32'd1);
    reset  = 1'b0;
    bvalid = 1'b1;
    #1;
    chk("rstmid bready at assert", 32'(bready), 32'd0);
    chk("rstmid lsu_wready at assert", 32'(lsu_wready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk($sformatf("rstmid%0d awvalid", k), 32'(awvalid), 32'd0);
      chk($sformatf("rstmid%0d wvalid", k), 32'(wvalid), 32'd0);
      chk($sformatf("rstmid%0d bready", k), 32'(bready), 32'd0);
      chk($sformatf("rstmid%0d lsu_wready", k), 32'(lsu_wready), 32'd0);
      chk($sformatf("rstmid%0d lsu_werr", k), 32'(lsu_werr), 32'd0);
    end
    reset  = 1'b1;
    bvalid = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    run_txn(32'h5000_0002, 32'h0000_7788, 4'h3, 0, 1, 3, 2'b00,
            32'h7788_0000, 4'hC, 3'd1, 4, 1'b0, "post_rst");

`ifdef YSYX_LSU_AXI_WR_TIMEOUT_EN
    // bvalid never arrives: 16 cycles in SEND/RESP, then a forced error completion.
    run_txn(32'h6000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 100000, 2'b00,
            32'hCAFE_F00D, 4'hF, 3'd2, 17, 1'b1, "timeout");
    idle_gap(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
